instruction_fetch_unit: RTL

Produces the data and load-enable for the instruction register. Holds the program counter, fetches one instruction word per handshake from instruction memory, and presents it with a one-cycle load pulse. Sits between the instruction memory port and the instruction register. Supports stall from the control unit and PC redirect for branches and jumps.

---
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Holds the program counter and fetches one word per memory handshake. Each
// accepted word goes to the instruction register with a one-cycle load pulse.
// Supports stall from the control unit and PC redirect for branches and jumps.
// Optional build macro FETCH_TIMEOUT_EN: bounds the wait for mem_ack and
// parks the unit in a sticky FAULT state when the bound is hit.
//
// Handshake: in REQ, mem_req=1 and mem_addr is the fetch address. A cycle
// with mem_ack=1 completes the fetch on that clock edge (zero-wait allowed).
// mem_ack is ignored in every other state. ir_L marks the single cycle in
// which ir_D/pc hold a freshly fetched instruction.
module instruction_fetch_unit #(
    parameter int N        = 32,
    parameter int AW       = 32,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic          clock,
    input  logic          R,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  ir_D,
    output logic          ir_L,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] pc,
    output logic          fetch_fault,
    output logic [2:0]    state_dbg
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_next_q, pc_next_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [N-1:0]  ir_d_q, ir_d_d;
    logic          discard_q, discard_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          fault_q, fault_d;
`endif

    // Next-state, PC and instruction-data computation
    always_comb begin
        state_d   = state_q;
        pc_next_d = pc_next_q;
        pc_d      = pc_q;
        ir_d_d    = ir_d_q;
        discard_d = discard_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (redirect) pc_next_d = redirect_pc;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    // A word returned together with a redirect is stale: drop it.
                    pc_next_d = redirect_pc;
                end else if (mem_ack && !discard_q) begin
                    ir_d_d    = mem_rdata;
                    pc_d      = pc_next_q;
                    pc_next_d = pc_next_q + AW'(PC_STEP);
                    state_d   = ST_ISSUE;
                end else if (mem_ack) begin
                    discard_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (redirect) pc_next_d = redirect_pc;
                state_d = stall ? ST_HOLD : ST_REQ;
            end
            ST_HOLD: begin
                if (redirect) pc_next_d = redirect_pc;
                if (!stall) state_d = ST_REQ;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (state_q == ST_REQ) begin
            if (mem_ack) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else if (state_d == ST_REQ) begin
            wait_cnt_d = '0;
        end
`endif
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clock or posedge R) begin
        if (R) begin
            state_q   <= ST_IDLE;
            pc_next_q <= AW'(RESET_PC);
            pc_q      <= AW'(RESET_PC);
            ir_d_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_next_q <= pc_next_d;
            pc_q      <= pc_d;
            ir_d_q    <= ir_d_d;
            discard_q <= discard_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter and sticky fault flag
    always_ff @(posedge clock or posedge R) begin
        if (R) begin
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = (state_q == ST_REQ) ? pc_next_q : '0;
    assign ir_L      = (state_q == ST_ISSUE);
    assign ir_D      = ir_d_q;
    assign pc        = pc_q;
    assign state_dbg = state_q;

endmodule
